// File: rtl/router_pkg.sv
// Shared router types and constants.
// Includes the flit-status unpacking helper used by the output ports.
package router_pkg;

    localparam int NUM_VCS        = 4;
    localparam int BUF_DEPTH      = 4;
    localparam int VC_W           = $clog2(NUM_VCS);
    localparam int CH_STATUS_BITS = 3 + VC_W;

    typedef enum logic [1:0] {
        VC_IDLE,
        VC_ACTIVE,
        VC_DRAIN
    } vc_state_t;

    typedef struct packed {
        logic            valid;
        logic [VC_W-1:0] vc;
        logic            head;
        logic            tail;
    } flit_status_t;

    // Layout, MSB first: {valid, vc, head, tail}
    function automatic flit_status_t unpack_flit_status(
        input logic [CH_STATUS_BITS-1:0] s
    );
        flit_status_t f;
        f.valid = s[CH_STATUS_BITS-1];
        f.vc    = s[2 +: VC_W];
        f.head  = s[1];
        f.tail  = s[0];
        return f;
    endfunction

endpackage

// File: rtl/vc_credit_counter.sv
// One VC's downstream credit counter, allocation FSM and error terms.
// Counts saturate at 0 and BUF_DEPTH; errors are sticky until reset.
module vc_credit_counter
    import router_pkg::*;
#(
    parameter int BUF_DEPTH = router_pkg::BUF_DEPTH,
    parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec,
    input  logic             inc,
    input  logic             alloc,
    input  logic             head,
    input  logic             tail,
    output logic [CNT_W-1:0] count,
    output logic             avail,
    output logic             free,
    output logic             err_ovf,
    output logic             err_udf
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

    vc_state_t        state;
    vc_state_t        state_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             ovf_evt;
    logic             udf_evt;

    // Saturating count update; a coincident inc and dec cancel out
    always_comb begin
        count_nxt = count;
        ovf_evt   = 1'b0;
        udf_evt   = 1'b0;
        if (dec && !inc) begin
            if (count == '0) udf_evt = 1'b1;
            else             count_nxt = count - 1'b1;
        end else if (inc && !dec) begin
            if (count == FULL) ovf_evt = 1'b1;
            else               count_nxt = count + 1'b1;
        end
    end

    // Next VC state; drain completes once the next count is full again
    always_comb begin
        state_nxt = state;
        unique case (state)
            VC_IDLE: begin
                if (alloc)
                    state_nxt = (dec && head && tail) ? VC_DRAIN : VC_ACTIVE;
            end
            VC_ACTIVE: begin
                if (dec && tail) state_nxt = VC_DRAIN;
            end
            VC_DRAIN: begin
                if (count_nxt == FULL) state_nxt = VC_IDLE;
            end
            default: state_nxt = VC_IDLE;
        endcase
    end

    // State, count and sticky error registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= VC_IDLE;
            count   <= FULL;
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            err_ovf <= err_ovf | ovf_evt;
            err_udf <= err_udf | udf_evt;
        end
    end

    // Status decoded from the registered state and count
    always_comb begin
        avail = (count != '0);
        free  = (state == VC_IDLE) && (count == FULL);
    end

endmodule

// File: rtl/out_vc_credit_tracker.sv
// Credit and VC-state tracker for one router output port.
// Decodes flit and allocation events per VC and merges error flags.
module out_vc_credit_tracker
    import router_pkg::*;
#(
    parameter int NUM_VCS   = router_pkg::NUM_VCS,
    parameter int BUF_DEPTH = router_pkg::BUF_DEPTH,
    parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flit_valid,
    input  logic [$clog2(NUM_VCS)-1:0] flit_vc,
    input  logic                       flit_head,
    input  logic                       flit_tail,
    input  logic [NUM_VCS-1:0]         credit_in,
    input  logic                       vc_alloc_valid,
    input  logic [$clog2(NUM_VCS)-1:0] vc_alloc_id,
    output logic [NUM_VCS-1:0]         credit_avail,
    output logic [NUM_VCS-1:0]         vc_free,
    output logic [NUM_VCS*CNT_W-1:0]   credit_count,
    output logic                       err_overflow,
    output logic                       err_underflow
);

    localparam int VW = $clog2(NUM_VCS);

    logic [NUM_VCS-1:0] ovf_v;
    logic [NUM_VCS-1:0] udf_v;

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
        logic dec;
        logic alloc;

        assign dec   = flit_valid && (flit_vc == VW'(v));
        assign alloc = vc_alloc_valid && (vc_alloc_id == VW'(v));

        vc_credit_counter #(
            .BUF_DEPTH (BUF_DEPTH),
            .CNT_W     (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .dec     (dec),
            .inc     (credit_in[v]),
            .alloc   (alloc),
            .head    (flit_head),
            .tail    (flit_tail),
            .count   (credit_count[v*CNT_W +: CNT_W]),
            .avail   (credit_avail[v]),
            .free    (vc_free[v]),
            .err_ovf (ovf_v[v]),
            .err_udf (udf_v[v])
        );
    end

    assign err_overflow  = |ovf_v;
    assign err_underflow = |udf_v;

endmodule

// File: tb/tb_out_vc_credit_tracker.sv
// Directed vector bench for out_vc_credit_tracker.
// Each vector is the input for one cycle and the state after its edge.
module tb_out_vc_credit_tracker;

    typedef struct {
        logic        rst;
        logic        fv;
        logic [1:0]  fvc;
        logic        fh;
        logic        ft;
        logic [3:0]  cr;
        logic        av;
        logic [1:0]  aid;
        logic [11:0] cnt;
        logic [3:0]  avail;
        logic [3:0]  free;
        logic        eo;
        logic        eu;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flit_valid;
    logic [1:0]  flit_vc;
    logic        flit_head;
    logic        flit_tail;
    logic [3:0]  credit_in;
    logic        vc_alloc_valid;
    logic [1:0]  vc_alloc_id;
    logic [3:0]  credit_avail;
    logic [3:0]  vc_free;
    logic [11:0] credit_count;
    logic        err_overflow;
    logic        err_underflow;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs[$];

    out_vc_credit_tracker dut (
        .clk            (clk),
        .reset          (reset),
        .flit_valid     (flit_valid),
        .flit_vc        (flit_vc),
        .flit_head      (flit_head),
        .flit_tail      (flit_tail),
        .credit_in      (credit_in),
        .vc_alloc_valid (vc_alloc_valid),
        .vc_alloc_id    (vc_alloc_id),
        .credit_avail   (credit_avail),
        .vc_free        (vc_free),
        .credit_count   (credit_count),
        .err_overflow   (err_overflow),
        .err_underflow  (err_underflow)
    );

    always #5 clk = ~clk;

    // The allocator may only claim a VC that is free
    a_alloc_free: assert property (@(posedge clk) disable iff (reset)
        vc_alloc_valid |-> vc_free[vc_alloc_id]);

    function automatic logic [11:0] cn(int c3, int c2, int c1, int c0);
        return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    endfunction

    function automatic vec_t mk(
        logic rst, logic fv, logic [1:0] fvc, logic fh, logic ft,
        logic [3:0] cr, logic av, logic [1:0] aid,
        logic [11:0] cnt, logic [3:0] avail, logic [3:0] free,
        logic eo, logic eu
    );
        vec_t r;
        r.rst = rst; r.fv = fv; r.fvc = fvc; r.fh = fh; r.ft = ft;
        r.cr = cr; r.av = av; r.aid = aid;
        r.cnt = cnt; r.avail = avail; r.free = free;
        r.eo = eo; r.eu = eu;
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        bit bad;
        reset          = v.rst;
        flit_valid     = v.fv;
        flit_vc        = v.fvc;
        flit_head      = v.fh;
        flit_tail      = v.ft;
        credit_in      = v.cr;
        vc_alloc_valid = v.av;
        vc_alloc_id    = v.aid;
        @(posedge clk);
        #1;
        bad = 1'b0;
        n_vec++;
        if (credit_count !== v.cnt) begin
            $display("FAIL %s count: got %h want %h", tag, credit_count, v.cnt);
            bad = 1'b1;
        end
        if (credit_avail !== v.avail) begin
            $display("FAIL %s avail: got %b want %b", tag, credit_avail, v.avail);
            bad = 1'b1;
        end
        if (vc_free !== v.free) begin
            $display("FAIL %s free: got %b want %b", tag, vc_free, v.free);
            bad = 1'b1;
        end
        if (err_overflow !== v.eo) begin
            $display("FAIL %s ovf: got %b want %b", tag, err_overflow, v.eo);
            bad = 1'b1;
        end
        if (err_underflow !== v.eu) begin
            $display("FAIL %s udf: got %b want %b", tag, err_underflow, v.eu);
            bad = 1'b1;
        end
        if (bad) n_bad++;
    endtask

    initial begin
        reset = 1'b1;
        flit_valid = 1'b0; flit_vc = '0; flit_head = 1'b0;
        flit_tail = 1'b0; credit_in = '0;
        vc_alloc_valid = 1'b0; vc_alloc_id = '0;

        // reset and idle
        vecs.push_back(mk(1,0,0,0,0,4'b0000,0,0, cn(4,4,4,4),4'hF,4'hF,0,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,0,0,0,0,4'b0000,0,0, cn(4,4,4,4),4'hF,4'hF,0,0));
        // 4-flit packet on VC1
        vecs.push_back(mk(0,0,0,0,0,4'b0000,1,1, cn(4,4,4,4),4'hF,4'b1101,0,0));
        vecs.push_back(mk(0,1,1,1,0,4'b0000,0,0, cn(4,4,3,4),4'hF,4'b1101,0,0));
        vecs.push_back(mk(0,1,1,0,0,4'b0000,0,0, cn(4,4,2,4),4'hF,4'b1101,0,0));
        vecs.push_back(mk(0,1,1,0,0,4'b0000,0,0, cn(4,4,1,4),4'hF,4'b1101,0,0));
        vecs.push_back(mk(0,1,1,0,1,4'b0000,0,0, cn(4,4,0,4),4'b1101,4'b1101,0,0));
        // credits return, VC1 free right after the fourth
        vecs.push_back(mk(0,0,0,0,0,4'b0010,0,0, cn(4,4,1,4),4'hF,4'b1101,0,0));
        vecs.push_back(mk(0,0,0,0,0,4'b0010,0,0, cn(4,4,2,4),4'hF,4'b1101,0,0));
        vecs.push_back(mk(0,0,0,0,0,4'b0010,0,0, cn(4,4,3,4),4'hF,4'b1101,0,0));
        vecs.push_back(mk(0,0,0,0,0,4'b0010,0,0, cn(4,4,4,4),4'hF,4'hF,0,0));
        // VC2 to 2, then coincident flit and credit
        vecs.push_back(mk(0,1,2,0,0,4'b0000,0,0, cn(4,3,4,4),4'hF,4'b1011,0,0));
        vecs.push_back(mk(0,1,2,0,0,4'b0000,0,0, cn(4,2,4,4),4'hF,4'b1011,0,0));
        vecs.push_back(mk(0,1,2,0,0,4'b0100,0,0, cn(4,2,4,4),4'hF,4'b1011,0,0));
        vecs.push_back(mk(0,0,0,0,0,4'b0100,0,0, cn(4,3,4,4),4'hF,4'b1011,0,0));
        vecs.push_back(mk(0,0,0,0,0,4'b0100,0,0, cn(4,4,4,4),4'hF,4'hF,0,0));
        // VC0 drained to 0, then underflow
        vecs.push_back(mk(0,1,0,0,0,4'b0000,0,0, cn(4,4,4,3),4'hF,4'b1110,0,0));
        vecs.push_back(mk(0,1,0,0,0,4'b0000,0,0, cn(4,4,4,2),4'hF,4'b1110,0,0));
        vecs.push_back(mk(0,1,0,0,0,4'b0000,0,0, cn(4,4,4,1),4'hF,4'b1110,0,0));
        vecs.push_back(mk(0,1,0,0,0,4'b0000,0,0, cn(4,4,4,0),4'b1110,4'b1110,0,0));
        vecs.push_back(mk(0,1,0,0,0,4'b0000,0,0, cn(4,4,4,0),4'b1110,4'b1110,0,1));
        vecs.push_back(mk(0,0,0,0,0,4'b0000,0,0, cn(4,4,4,0),4'b1110,4'b1110,0,1));
        // overflow on full VC3
        vecs.push_back(mk(0,0,0,0,0,4'b1000,0,0, cn(4,4,4,0),4'b1110,4'b1110,1,1));
        vecs.push_back(mk(1,0,0,0,0,4'b0000,0,0, cn(4,4,4,4),4'hF,4'hF,0,0));
        // reset with VC1 ACTIVE at count 1, flit in the reset cycle
        vecs.push_back(mk(0,0,0,0,0,4'b0000,1,1, cn(4,4,4,4),4'hF,4'b1101,0,0));
        vecs.push_back(mk(0,1,1,1,0,4'b0000,0,0, cn(4,4,3,4),4'hF,4'b1101,0,0));
        vecs.push_back(mk(0,1,1,0,0,4'b0000,0,0, cn(4,4,2,4),4'hF,4'b1101,0,0));
        vecs.push_back(mk(0,1,1,0,0,4'b0000,0,0, cn(4,4,1,4),4'hF,4'b1101,0,0));
        vecs.push_back(mk(1,1,1,0,0,4'b0000,0,0, cn(4,4,4,4),4'hF,4'hF,0,0));
        // single-flit packet in the allocation cycle
        vecs.push_back(mk(0,1,2,1,1,4'b0000,1,2, cn(4,3,4,4),4'hF,4'b1011,0,0));
        vecs.push_back(mk(0,0,0,0,0,4'b0000,0,0, cn(4,3,4,4),4'hF,4'b1011,0,0));
        vecs.push_back(mk(0,0,0,0,0,4'b0100,0,0, cn(4,4,4,4),4'hF,4'hF,0,0));
        // tail with coincident credit at full: one DRAIN cycle
        vecs.push_back(mk(0,0,0,0,0,4'b0000,1,0, cn(4,4,4,4),4'hF,4'b1110,0,0));
        vecs.push_back(mk(0,1,0,0,1,4'b0001,0,0, cn(4,4,4,4),4'hF,4'b1110,0,0));
        vecs.push_back(mk(0,0,0,0,0,4'b0000,0,0, cn(4,4,4,4),4'hF,4'hF,0,0));

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Underflow on VC3 stays set across idle cycles until reset
        run_vec(mk(1,0,0,0,0,4'b0000,0,0, cn(4,4,4,4),4'hF,4'hF,0,0), "seq_rst");
        for (int i = 0; i < 4; i++)
            run_vec(mk(0,1,3,0,0,4'b0000,0,0, cn(3-i,4,4,4),
                       (i == 3) ? 4'b0111 : 4'hF, 4'b0111,0,0),
                    $sformatf("seq_dec%0d", i));
        run_vec(mk(0,1,3,0,0,4'b0000,0,0, cn(0,4,4,4),4'b0111,4'b0111,0,1),
                "seq_udf");
        for (int i = 0; i < 3; i++)
            run_vec(mk(0,0,0,0,0,4'b0000,0,0, cn(0,4,4,4),4'b0111,4'b0111,0,1),
                    $sformatf("seq_sticky%0d", i));
        run_vec(mk(0,0,0,0,0,4'b1000,0,0, cn(1,4,4,4),4'hF,4'b0111,0,1),
                "seq_credit");
        run_vec(mk(1,0,0,0,0,4'b0000,0,0, cn(4,4,4,4),4'hF,4'hF,0,0),
                "seq_clear");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/out_vc_credit_tracker.md
Name: out_vc_credit_tracker

Overview:
- Upstream-side credit and VC-state tracker for one router output port.
- Consumes the per-VC credit pulses returned by the downstream router through the mesh control web, and the flit status this port drives onto the link.
- Keeps a per-VC count of free downstream buffer slots and a per-VC allocation state, so the switch/VC allocators only send to VCs that have space and are free.
- Instantiated NUM_PORTS-1 times per router, one per mesh direction.

Parameters:
- NUM_VCS, 4, virtual channels per port (from router_pkg).
- BUF_DEPTH, 4, downstream input-buffer depth per VC in flits; also the credit reset value.
- CNT_W, $clog2(BUF_DEPTH+1), credit counter width (derived, not overridden).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- flit_valid  input  1  a flit leaves this port this cycle.
- flit_vc  input  $clog2(NUM_VCS)  VC of the departing flit.
- flit_head  input  1  departing flit is a head flit.
- flit_tail  input  1  departing flit is a tail flit; head and tail both set means a single-flit packet.
- credit_in  input  NUM_VCS  one-cycle credit pulse per VC, from downstream (in_credit).
- vc_alloc_valid  input  1  VC allocator claims a downstream VC.
- vc_alloc_id  input  $clog2(NUM_VCS)  VC being claimed.
- credit_avail  output  NUM_VCS  count>0 per VC.
- vc_free  output  NUM_VCS  VC is IDLE and at full credit, so it can be allocated.
- credit_count  output  NUM_VCS x CNT_W  current counts.
- err_overflow  output  1  sticky: a credit arrived while count==BUF_DEPTH.
- err_underflow  output  1  sticky: a flit was sent while count==0.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values:
  - all counts = BUF_DEPTH;
  - all VCs IDLE;
  - credit_avail = all ones;
  - vc_free = all ones;
  - error flags = 0.
  - Reset asserted mid-packet discards all in-flight state next edge, with no error reporting.
- Counter update, per VC each cycle: next = count − dec + inc.
  - dec = flit_valid && flit_vc==v.
  - inc = credit_in[v].
  - Simultaneous dec and inc leaves the count unchanged, and neither error fires.
- Count saturation:
  - dec with count==0 and no inc: count holds at 0, err_underflow set.
  - inc with count==BUF_DEPTH and no dec: count holds, err_overflow set.
  - Error flags clear only on reset.
- Outputs are registered, derived from next-state values, so they are valid in the cycle after the event. Credit latency from pulse to credit_avail rising is 1 cycle.
- Per-VC FSM, IDLE -> ACTIVE -> DRAIN -> IDLE:
  - IDLE -> ACTIVE on vc_alloc_valid with vc_alloc_id==v.
  - ACTIVE -> DRAIN on a sent flit for v with flit_tail.
  - DRAIN -> IDLE when the count reaches BUF_DEPTH, i.e. the downstream buffer is fully drained.
  - A single-flit packet (head+tail) sent in the allocation cycle moves IDLE -> DRAIN directly.
  - DRAIN with count already BUF_DEPTH after the tail cycle moves straight to IDLE. This happens only if inc and dec coincide at full, and goes through a single DRAIN cycle.
  - vc_alloc_valid targeting a non-IDLE VC is ignored, no state change. The allocator must not issue it; the assertion lives in the testbench.
  - A flit for an IDLE VC without allocation still updates the count. The FSM is unaffected and err_underflow rules apply.
- vc_free[v] = (state==IDLE) && (count==BUF_DEPTH).

Decomposition:
- Into router_pkg:
  - vc_state_t enum {VC_IDLE, VC_ACTIVE, VC_DRAIN};
  - BUF_DEPTH;
  - a flit-status unpacking function (valid/vc/head/tail fields of CH_STATUS_BITS), so the router top can feed this block from outport_flit_status.
- Natural sub-module: vc_credit_counter, which holds one VC's counter, FSM and error terms. It is instantiated NUM_VCS times by generate; the top does only decode and the OR of error flags.

Test Plan:
- Reset, then idle 5 cycles -> all counts 4, credit_avail=4'b1111, vc_free=4'b1111, errors 0.
- Allocate VC1, send 4 flits on VC1 (head..tail) -> count[1] 4,3,2,1,0 one cycle after each flit; credit_avail[1]=0; state DRAIN; vc_free[1]=0.
- Return 4 credits on VC1 -> count[1] climbs to 4; VC1 enters IDLE and vc_free[1]=1 in the cycle after the 4th credit.
- VC2 at count 2: flit and credit on VC2 in the same cycle -> count[2] stays 2, no error.
- Send a flit on VC0 with count 0 -> count stays 0, err_underflow=1 and stays 1 until reset. Credit on VC3 at 4 -> err_overflow=1.
- Assert reset while VC1 is in ACTIVE at count 1 -> next cycle count[1]=4, IDLE, vc_free[1]=1. Also cover a single-flit head+tail packet in the allocation cycle -> DRAIN, then IDLE once its credit returns.
